mmio_uart_tx: RTL



---
 rtl/mmio_uart_tx_if.sv | 23 ++
 rtl/mmio_uart_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory port between the core and the UART transmitter
interface mmio_uart_tx_if #(
    parameter int WIDTH = 32
);
    logic             sel;
    logic [3:0]       addr;
    logic             we;
    logic [2:0]       bytes;
    logic             rd_unsigned;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             misaligned;

    modport master (
        output sel, addr, we, bytes, rd_unsigned, wr_data,
        input  rd_data, misaligned
    );

    modport slave (
        input  sel, addr, we, bytes, rd_unsigned, wr_data,
        output rd_data, misaligned
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status and divisor registers
module mmio_uart_tx #(
    parameter int          WIDTH       = 32,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic           clk,
    input  logic           rst,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           irq
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wptr, rptr, count, count_n;
    logic [15:0]      div, fdiv, fdiv_n, cnt, cnt_n;
    logic [7:0]       sh, sh_n;
    logic [2:0]       idx, idx_n;
    logic             ovf, pop, tx_n, irq_n;
    logic             size_ok, align_ok, acc, wr, push, push_ok, clr, div_wr, be0, be1;
    logic             full, empty, bit_end;
    logic [31:0]      cnt32;
    logic [3:0]       occ;
    logic [WIDTH-1:0] status, rword, rshift, rext;
    logic [15:0]      rhalf;
    logic [7:0]       rbyte;
    logic             unused_wr_hi;

    assign unused_wr_hi = ^bus.wr_data[WIDTH-1:16];

    assign size_ok  = bus.bytes == 3'd1 || bus.bytes == 3'd2 || bus.bytes == 3'd4;
    assign align_ok = !((bus.bytes == 3'd2 && bus.addr[0]) || (bus.bytes == 3'd4 && bus.addr[1:0] != 2'd0));
    assign bus.misaligned = bus.sel && !(size_ok && align_ok);
    assign acc     = bus.sel && size_ok && align_ok;
    assign wr      = acc && bus.we;
    assign push    = wr && bus.addr[3:2] == 2'd0;
    assign clr     = wr && bus.addr[3:2] == 2'd1 && bus.wr_data[3];
    assign div_wr  = wr && bus.addr[3:2] == 2'd2;
    assign be0     = bus.bytes == 3'd4 || (bus.bytes == 3'd2 && !bus.addr[1]) || (bus.bytes == 3'd1 && bus.addr[1:0] == 2'd0);
    assign be1     = bus.bytes == 3'd4 || (bus.bytes == 3'd2 && !bus.addr[1]) || (bus.bytes == 3'd1 && bus.addr[1:0] == 2'd1);

    assign count   = wptr - rptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign count_n = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    assign cnt32   = 32'(count);
    assign occ     = cnt32 > 32'd15 ? 4'hF : cnt32[3:0];
    assign bit_end = cnt == fdiv - 16'd1;

    assign status = WIDTH'({occ, ovf, state != IDLE, empty, full});
    assign rword  = bus.addr[3:2] == 2'd1 ? status : bus.addr[3:2] == 2'd2 ? WIDTH'(div) : '0;
    assign rshift = rword >> {bus.addr[1:0], 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = bus.addr[1] ? rword[31:16] : rword[15:0];
    assign rext   = bus.bytes == 3'd1 ? {{(WIDTH-8){!bus.rd_unsigned && rbyte[7]}}, rbyte} :
                    bus.bytes == 3'd2 ? {{(WIDTH-16){!bus.rd_unsigned && rhalf[15]}}, rhalf} : rword;

    // FIFO storage; no reset needed since occupancy comes from the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= bus.wr_data[7:0];
    end

    // FIFO pointers, sticky overflow and divisor register with byte-lane writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            div  <= DEFAULT_DIV;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && full) ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
            if (div_wr && be0) div[7:0] <= bus.wr_data[7:0];
            if (div_wr && be1) div[15:8] <= bus.bytes == 3'd1 ? bus.wr_data[7:0] : bus.wr_data[15:8];
        end
    end

    // Serialiser next state: bit timing, shift, and FIFO pop at frame boundaries
    always_comb begin
        state_n = state;
        sh_n    = sh;
        fdiv_n  = fdiv;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        pop     = 1'b0;
        case (state)
            IDLE:  cnt_n = '0;
            START: if (bit_end) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = DATA;
            end
            DATA:  if (bit_end) begin
                cnt_n   = '0;
                sh_n    = sh >> 1;
                idx_n   = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            default: if (bit_end) begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        if ((state == IDLE || (state == STOP && bit_end)) && !empty) begin
            pop     = 1'b1;
            sh_n    = mem[rptr[AW-1:0]];
            fdiv_n  = div == '0 ? 16'd1 : div;
            cnt_n   = '0;
            state_n = START;
        end
        tx_n  = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
        irq_n = count_n == '0 && state_n == IDLE;
    end

    // Serialiser state, registered line output and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            fdiv  <= 16'd1;
            cnt   <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            irq   <= 1'b1;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            fdiv  <= fdiv_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            tx    <= tx_n;
            irq   <= irq_n;
        end
    end

    // Registered load data, one cycle after the access; held while not selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.rd_data <= '0;
        else if (bus.sel) bus.rd_data <= acc && !bus.we ? rext : '0;
    end
endmodule
